// File: rtl/signed_divider8.sv
// Sequential signed divider: restoring shift/subtract on operand magnitudes,
// followed by a sign-correction step. Quotient truncates toward zero and the
// remainder takes the sign of the dividend.
module signed_divider8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t           state_reg,  state_next;
    logic [WIDTH-1:0] a_reg,      a_next;
    logic [WIDTH-1:0] b_reg,      b_next;
    logic [WIDTH-1:0] bmag_reg,   bmag_next;
    logic [WIDTH:0]   rem_reg,    rem_next;
    logic [WIDTH-1:0] qsh_reg,    qsh_next;
    logic [CW-1:0]    cnt_reg,    cnt_next;
    logic [WIDTH-1:0] q_reg,      q_next;
    logic [WIDTH-1:0] r_reg,      r_next;
    logic             busy_reg,   busy_next;
    logic             done_reg,   done_next;
    logic             dbz_reg,    dbz_next;
    logic             ovf_reg,    ovf_next;

    // Magnitudes of the live operands; |MIN_VAL| wraps to MIN_VAL, which is
    // exactly 2^(WIDTH-1) when read as unsigned.
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    assign a_mag = A[WIDTH-1] ? -A : A;
    assign b_mag = B[WIDTH-1] ? -B : B;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and try subtracting the divisor. The extra top bit of the
    // trial value is its borrow, i.e. the "went negative" indicator.
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] trial;
    assign rem_shift = {rem_reg[WIDTH-1:0], qsh_reg[WIDTH-1]};
    assign trial     = {1'b0, rem_shift} - {2'b00, bmag_reg};

    // State and datapath registers; reset aborts any operation silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            bmag_reg  <= '0;
            rem_reg   <= '0;
            qsh_reg   <= '0;
            cnt_reg   <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            dbz_reg   <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            bmag_reg  <= bmag_next;
            rem_reg   <= rem_next;
            qsh_reg   <= qsh_next;
            cnt_reg   <= cnt_next;
            q_reg     <= q_next;
            r_reg     <= r_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            dbz_reg   <= dbz_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Next-state and datapath logic; everything holds unless a state acts.
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        bmag_next  = bmag_reg;
        rem_next   = rem_reg;
        qsh_next   = qsh_reg;
        cnt_next   = cnt_reg;
        q_next     = q_reg;
        r_next     = r_reg;
        busy_next  = busy_reg;
        done_next  = done_reg;
        dbz_next   = dbz_reg;
        ovf_next   = ovf_reg;

        case (state_reg)
            IDLE: begin
                done_next = 1'b0;
                busy_next = 1'b0;
                if (start) begin
                    a_next    = A;
                    b_next    = B;
                    bmag_next = b_mag;
                    busy_next = 1'b1;
                    dbz_next  = 1'b0;
                    ovf_next  = 1'b0;
                    if (B == '0) begin
                        // Nothing to iterate: report immediately.
                        q_next     = '0;
                        r_next     = A;
                        dbz_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        rem_next   = '0;
                        qsh_next   = a_mag;
                        cnt_next   = '0;
                        state_next = CALC;
                    end
                end
            end

            CALC: begin
                if (!trial[WIDTH+1]) begin
                    rem_next = trial[WIDTH:0];
                    qsh_next = {qsh_reg[WIDTH-2:0], 1'b1};
                end else begin
                    rem_next = rem_shift;
                    qsh_next = {qsh_reg[WIDTH-2:0], 1'b0};
                end
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_ITER) begin
                    state_next = FIX;
                end
            end

            FIX: begin
                // Sign correction. MIN_VAL / -1 falls out naturally as the
                // wrapped MIN_VAL with zero remainder; only the flag is extra.
                q_next     = (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) ? -qsh_reg : qsh_reg;
                r_next     = a_reg[WIDTH-1] ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
                ovf_next   = (a_reg == MIN_VAL) && (b_reg == {WIDTH{1'b1}});
                state_next = DONE;
            end

            DONE: begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign Q           = q_reg;
    assign R           = r_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign div_by_zero = dbz_reg;
    assign overflow    = ovf_reg;

endmodule

// File: tb/tb_signed_divider8.sv
// Directed bench for signed_divider8: hand-computed vectors for each feature,
// followed by a random sample checked against a behavioural model.
module tb_signed_divider8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] Q;
    logic [7:0] R;
    logic       busy;
    logic       done;
    logic       div_by_zero;
    logic       overflow;

    int n_cmp = 0;
    int n_bad = 0;

    signed_divider8 #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (A),
        .B           (B),
        .Q           (Q),
        .R           (R),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Pulse start for exactly one rising edge; returns at the falling edge
    // right after the capture edge.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called right after start_op. Returns latency in edges after the
    // capture edge (-1 on timeout) and the number of cycles busy was high.
    task automatic wait_done(output int lat, output int busy_cycles);
        int n;
        n = 1;
        busy_cycles = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
            if (busy === 1'b1) busy_cycles++;
        end
        lat = (done === 1'b1) ? n - 1 : -1;
    endtask

    function automatic logic [17:0] model(input logic [7:0] a, input logic [7:0] b);
        int sa, sb, q, r;
        logic dz, ov;
        sa = {{24{a[7]}}, a};
        sb = {{24{b[7]}}, b};
        dz = 1'b0;
        ov = 1'b0;
        if (sb == 0) begin
            q  = 0;
            r  = sa;
            dz = 1'b1;
        end else if (sa == -128 && sb == -1) begin
            q  = -128;
            r  = 0;
            ov = 1'b1;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return {q[7:0], r[7:0], dz, ov};
    endfunction

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        A     = 8'h00;
        B     = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({Q, R, busy, done, div_by_zero, overflow} !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_state: got %h expected %h",
                     {Q, R, busy, done, div_by_zero, overflow}, 20'h0);
        end
        $display("reset: Q=%h R=%h busy=%b done=%b", Q, R, busy, done);
    endtask

    // Runs one operation, compares latency and {Q,R,dbz,ovf}, and checks that
    // done drops again after a single cycle.
    task automatic run_directed(input string name, input logic [7:0] a, input logic [7:0] b,
                                input int exp_lat, input logic [17:0] exp_res);
        int lat, bc;
        start_op(a, b);
        wait_done(lat, bc);
        n_cmp++;
        if (lat !== exp_lat) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
        end
        n_cmp++;
        if ({Q, R, div_by_zero, overflow} !== exp_res) begin
            n_bad++;
            $display("FAIL %s_result: got Q=%h R=%h dbz=%b ovf=%b expected Q=%h R=%h dbz=%b ovf=%b",
                     name, Q, R, div_by_zero, overflow,
                     exp_res[17:10], exp_res[9:2], exp_res[1], exp_res[0]);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_done_width: got %b expected 0", name, done);
        end
        $display("%s: A=%h B=%h -> Q=%h R=%h dbz=%b ovf=%b lat=%0d",
                 name, a, b, exp_res[17:10], exp_res[9:2], exp_res[1], exp_res[0], lat);
    endtask

    task automatic test_unsigned();
        int lat, bc;
        start_op(8'h64, 8'h07);
        wait_done(lat, bc);
        n_cmp++;
        if (bc !== 10) begin
            n_bad++;
            $display("FAIL unsigned_busy_cycles: got %0d expected 10", bc);
        end
        n_cmp++;
        if ({Q, R, div_by_zero, overflow} !== {8'h0E, 8'h02, 2'b00}) begin
            n_bad++;
            $display("FAIL unsigned_result: got Q=%h R=%h dbz=%b ovf=%b expected Q=0e R=02 dbz=0 ovf=0",
                     Q, R, div_by_zero, overflow);
        end
        n_cmp++;
        if (lat !== 10) begin
            n_bad++;
            $display("FAIL unsigned_latency: got %0d expected 10", lat);
        end
        $display("unsigned: 100/7 -> Q=%h R=%h busy_cycles=%0d lat=%0d", Q, R, bc, lat);
        run_directed("unsigned_repeat", 8'h64, 8'h07, 10, {8'h0E, 8'h02, 2'b00});
    endtask

    task automatic test_signs();
        run_directed("neg_pos", 8'h9C, 8'h07, 10, {8'hF2, 8'hFE, 2'b00});
        run_directed("pos_neg", 8'h64, 8'hF9, 10, {8'hF2, 8'h02, 2'b00});
        run_directed("neg_neg", 8'h9C, 8'hF9, 10, {8'h0E, 8'hFE, 2'b00});
    endtask

    task automatic test_extremes();
        run_directed("min_div_1",    8'h80, 8'h01, 10, {8'h80, 8'h00, 2'b00});
        run_directed("min_div_m1",   8'h80, 8'hFF, 10, {8'h80, 8'h00, 2'b01});
        run_directed("max_div_min",  8'h7F, 8'h80, 10, {8'h00, 8'h7F, 2'b00});
    endtask

    task automatic test_div_zero();
        run_directed("div_zero",     8'h05, 8'h00, 1,  {8'h00, 8'h05, 2'b10});
        run_directed("after_dz",     8'h09, 8'h03, 10, {8'h03, 8'h00, 2'b00});
    endtask

    task automatic test_ignore_start();
        int lat, bc, extra;
        start_op(8'h64, 8'h07);
        repeat (2) @(negedge clk);
        A     = 8'h32;
        B     = 8'h03;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A     = 8'h00;
        B     = 8'h00;
        wait_done(lat, bc);
        n_cmp++;
        if ({Q, R, div_by_zero, overflow} !== {8'h0E, 8'h02, 2'b00}) begin
            n_bad++;
            $display("FAIL ignore_start_result: got Q=%h R=%h dbz=%b ovf=%b expected Q=0e R=02 dbz=0 ovf=0",
                     Q, R, div_by_zero, overflow);
        end
        extra = 0;
        repeat (14) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_bad++;
            $display("FAIL ignore_start_extra_done: got %0d expected 0", extra);
        end
        $display("ignore_start: Q=%h R=%h extra_done=%0d", Q, R, extra);
    endtask

    task automatic test_back_to_back();
        int c, first, second;
        first  = -1;
        second = -1;
        @(negedge clk);
        A     = 8'h14;
        B     = 8'h03;
        start = 1'b1;
        c     = 0;
        while (second < 0 && c < 40) begin
            @(negedge clk);
            c++;
            if (done === 1'b1) begin
                if (first < 0) first = c;
                else second = c;
                n_cmp++;
                if ({Q, R, div_by_zero, overflow} !== {8'h06, 8'h02, 2'b00}) begin
                    n_bad++;
                    $display("FAIL back_to_back_result: got Q=%h R=%h expected Q=06 R=02", Q, R);
                end
            end
        end
        start = 1'b0;
        n_cmp++;
        if (second - first !== 11 || first < 0) begin
            n_bad++;
            $display("FAIL back_to_back_period: got %0d expected 11", second - first);
        end
        $display("back_to_back: done at cycles %0d and %0d", first, second);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int extra;
        start_op(8'h64, 8'h07);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, Q, R} !== 18'h0) begin
            n_bad++;
            $display("FAIL reset_mid_op: got busy=%b done=%b Q=%h R=%h expected all 0",
                     busy, done, Q, R);
        end
        rst   = 1'b0;
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_op_done: got %0d expected 0", extra);
        end
        $display("reset_mid_op: busy=%b Q=%h R=%h extra_done=%0d", busy, Q, R, extra);
        run_directed("after_reset", 8'h32, 8'h06, 10, {8'h08, 8'h02, 2'b00});
    endtask

    task automatic test_sweep();
        int lat, bc, bad;
        logic [7:0]  a, b;
        logic [17:0] exp_res;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            a = 8'($urandom);
            b = (i % 25 == 0) ? 8'h00 : 8'($urandom);
            exp_res = model(a, b);
            start_op(a, b);
            wait_done(lat, bc);
            n_cmp++;
            if ({Q, R, div_by_zero, overflow} !== exp_res || lat !== (b == 8'h00 ? 1 : 10)) begin
                n_bad++;
                bad++;
                $display("FAIL sweep_%0d: A=%h B=%h got Q=%h R=%h dbz=%b ovf=%b lat=%0d expected %h",
                         i, a, b, Q, R, div_by_zero, overflow, lat, exp_res);
            end
        end
        $display("sweep: 300 random operations, %0d bad", bad);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_unsigned();
        test_signs();
        test_extremes();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_op();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
